// File: rtl/root_prenorm.sv
// Operand pre-normaliser for root_newton: shifts the operand left in
// 2-bit steps into [0.25,1), issues start and holds d until ready.
module root_prenorm (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] a,
  input  logic        a_valid,
  output logic        a_ready,
  output logic [31:0] d,
  output logic        start,
  input  logic        root_busy,
  input  logic        root_ready,
  output logic [3:0]  shift,
  output logic        zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_nstate;
  logic [31:0] r_d;
  logic [31:0] w_d_n;
  logic [3:0]  r_shift;
  logic [3:0]  w_shift_n;
  logic        r_zero;
  logic        w_zero_n;
  logic        w_normed;

  assign w_normed = (r_d[31:30] != 2'b00);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
      r_d     <= '0;
      r_shift <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_d     <= w_d_n;
      r_shift <= w_shift_n;
      r_zero  <= w_zero_n;
    end
  end

  always_comb begin
    w_nstate  = r_state;
    w_d_n     = r_d;
    w_shift_n = r_shift;
    w_zero_n  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (a_valid) begin
          w_d_n     = a;
          w_shift_n = '0;
          if (a == 32'd0) w_zero_n = 1'b1;
          else            w_nstate = ST_NORM;
        end
      end
      ST_NORM: begin
        // a nonzero operand needs at most 15 steps, so shift cannot wrap
        if (!w_normed) begin
          w_d_n     = {r_d[29:0], 2'b00};
          w_shift_n = r_shift + 4'd1;
        end else if (!root_busy) begin
          w_nstate = ST_ISSUE;
        end
      end
      ST_ISSUE: w_nstate = ST_WAIT;
      ST_WAIT: begin
        if (root_ready) w_nstate = ST_IDLE;
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  assign a_ready = (r_state == ST_IDLE);
  assign busy    = !a_ready;
  assign start   = (r_state == ST_ISSUE);
  assign d       = r_d;
  assign shift   = r_shift;
  assign zero    = r_zero;

endmodule

// File: tb/tb_root_prenorm.sv
// Bench for root_prenorm: operand-level reference model checked every
// cycle, directed operands with literal results, then random traffic.
module tb_root_prenorm;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] a;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] d;
  logic        start;
  logic        root_busy;
  logic        root_ready;
  logic [3:0]  shift;
  logic        zero;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  root_prenorm dut (
    .clk        (clk),
    .clrn       (clrn),
    .a          (a),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .d          (d),
    .start      (start),
    .root_busy  (root_busy),
    .root_ready (root_ready),
    .shift      (shift),
    .zero       (zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // number of 2-bit steps = floor((31 - msb) / 2)
  function automatic int pairs(input logic [31:0] x);
    int msb;
    msb = 0;
    for (int i = 0; i < 32; i++) if (x[i]) msb = i;
    return (31 - msb) / 2;
  endfunction

  // model: phase 0 idle, 1 norm, 2 issue, 3 wait
  int          m_ph = 0;
  int          m_k, m_n;
  logic [31:0] m_a, m_d;
  logic [3:0]  m_s;
  logic        m_z;
  bit          m_live = 0;

  always @(posedge clk) begin
    if (!clrn) begin
      m_ph = 0; m_d = 0; m_s = 0; m_z = 0;
    end else begin
      m_z = 0;
      case (m_ph)
        0: if (a_valid) begin
          m_d = a; m_s = 0;
          if (a == 0) m_z = 1;
          else begin
            m_a = a; m_k = pairs(a); m_n = 0; m_ph = 1;
          end
        end
        1: if (m_n < m_k) begin
          m_n++;
          m_d = m_a << (2 * m_n);
          m_s = 4'(m_n);
        end else if (!root_busy) m_ph = 2;
        2: m_ph = 3;
        default: if (root_ready) m_ph = 0;
      endcase
    end
    m_live = 1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("a_ready", 32'(a_ready), 32'(m_ph == 0));
      chk("busy", 32'(busy), 32'(m_ph != 0));
      chk("start", 32'(start), 32'(m_ph == 2));
      chk("zero", 32'(zero), 32'(m_z));
      chk("d", d, m_d);
      chk("shift", 32'(shift), 32'(m_s));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!a_ready && t < 100) begin step(); t++; end
    chk("idle_timeout", 32'(a_ready), 32'd1);
  endtask

  task automatic run_op(input logic [31:0] op, input int stall,
                        input logic [31:0] ed, input logic [3:0] es,
                        input int elat);
    int j;
    wait_idle();
    a = op; a_valid = 1;
    root_busy = (stall > 0);
    step();
    a_valid = 0;
    j = 0;
    while (!start && j < 60) begin
      root_busy = (stall > 0) && (j + 1 <= elat - 1);
      step();
      j++;
    end
    root_busy = 0;
    chk("latency", 32'(j), 32'(elat));
    chk("issue_d", d, ed);
    chk("issue_shift", 32'(shift), 32'(es));
    a = 32'h1234_5678; a_valid = 1;
    step(); step();
    chk("wait_held", 32'(busy), 32'd1);
    a_valid = 0; root_ready = 1;
    step();
    root_ready = 0;
    chk("ret_ready", 32'(a_ready), 32'd1);
    chk("hold_d", d, ed);
    chk("hold_shift", 32'(shift), 32'(es));
  endtask

  initial begin
    clrn = 0; a = 0; a_valid = 0; root_busy = 0; root_ready = 0;
    chk("pairs_1", 32'(pairs(32'h1)), 32'd15);
    chk("pairs_2k", 32'(pairs(32'h0002_0000)), 32'd7);
    chk("pairs_top", 32'(pairs(32'hC000_0000)), 32'd0);
    step(); step();
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_d", d, 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    clrn = 1;
    step();

    run_op(32'h4000_0000, 0, 32'h4000_0000, 4'd0, 1);
    run_op(32'h0000_0001, 0, 32'h4000_0000, 4'd15, 16);
    run_op(32'h0002_0000, 0, 32'h8000_0000, 4'd7, 8);
    run_op(32'hC000_0000, 0, 32'hC000_0000, 4'd0, 1);

    a = 0; a_valid = 1;
    step();
    chk("zero_pulse", 32'(zero), 32'd1);
    chk("zero_ready", 32'(a_ready), 32'd1);
    run_op(32'hFFFE_0001, 0, 32'hFFFE_0001, 4'd0, 1);

    run_op(32'h4000_0000, 5, 32'h4000_0000, 4'd0, 6);
    run_op(32'h0000_0100, 3, 32'h4000_0000, 4'd11, 15);

    wait_idle();
    a = 32'h1; a_valid = 1;
    step();
    a_valid = 0;
    repeat (4) step();
    chk("mid_shift", 32'(shift), 32'd4);
    clrn = 0;
    step();
    clrn = 1;
    chk("rst_mid_d", d, 32'd0);
    chk("rst_mid_shift", 32'(shift), 32'd0);
    chk("rst_mid_ready", 32'(a_ready), 32'd1);
    repeat (20) begin
      step();
      chk("no_start", 32'(start), 32'd0);
    end

    repeat (4000) begin
      clrn       = ($urandom_range(0, 299) != 0);
      a_valid    = ($urandom_range(0, 1) == 1);
      a          = ($urandom_range(0, 9) == 0) ? 32'd0
                 : ($urandom >> $urandom_range(0, 31));
      root_busy  = ($urandom_range(0, 9) < 3);
      root_ready = ($urandom_range(0, 9) < 3);
      step();
    end
    clrn = 1; a_valid = 0; root_busy = 0; root_ready = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/root_prenorm.md
# root_prenorm

Operand pre-normalisation stage that sits directly upstream of `root_newton`. It accepts an arbitrary 32-bit unsigned operand and shifts it left in 2-bit steps until it is a normalised fraction in [0.25, 1), meaning bit 31 or bit 30 is set. It then issues a one-cycle `start` to `root_newton` and holds `d` stable until `root_newton` signals `ready`. The even shift count is exported so the downstream denormaliser can scale `q` by 2^-(shift).

## Interface
Parameters: none (datapath fixed at 32 bits).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `clrn`  in  1  synchronous, active-low reset
- `a`  in  32  unsigned operand
- `a_valid`  in  1  operand valid; sampled only while `a_ready`=1
- `a_ready`  out  1  block idle, can accept operand
- `d`  out  32  normalised fraction to `root_newton.d`
- `start`  out  1  one-cycle start pulse to `root_newton.start`
- `root_busy`  in  1  from `root_newton.busy`
- `root_ready`  in  1  from `root_newton.ready`
- `shift`  out  4  number of 2-bit left shifts applied (0..15)
- `zero`  out  1  one-cycle pulse: operand was 0, no root issued
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE
  - NORM: shift loop
  - ISSUE: `start` cycle
  - WAIT: awaiting `root_ready`
- Outputs are Moore decodes or registers:
  - `a_ready` = (state==IDLE)
  - `busy` = !`a_ready`
  - `start` = (state==ISSUE)
- IDLE:
  - If `a_valid` and `a`≠0: d←a, shift←0, go NORM.
  - If `a_valid` and `a`==0: d←0, shift←0, zero←1 for one cycle, stay IDLE. No `start` is issued.
- NORM, evaluated every edge:
  - If d[31:30]==00: d←d<<2, shift←shift+1, stay in NORM.
  - Else if `root_busy`==0: go ISSUE.
  - Else: stall in NORM with d unchanged.
- ISSUE: lasts exactly one cycle, then go WAIT unconditionally.
- WAIT:
  - On `root_ready`==1: go IDLE.
  - `root_busy` is ignored.
- Shift bound:
  - Maximum shift is 15 (a=1 → d=0x40000000).
  - `shift` never wraps, because a≠0 guarantees termination by 15.
- Hold rules:
  - `d` is constant from entry to ISSUE until return to IDLE.
  - `d` and `shift` stay held in IDLE until the next acceptance, so downstream samples them alongside `q`.
- Ignored inputs:
  - `root_ready` outside WAIT is ignored.
  - `a_valid` outside IDLE is ignored; the operand is not latched.
- Arithmetic: shifts are logical, zero-filled; no rounding. sqrt(a) = q·2^(16−shift).

## Timing
- Reset: `clrn`=0 at a rising edge forces state←IDLE, d←0, shift←0, zero←0. Resulting outputs:
  - `start`=0
  - `busy`=0
  - `a_ready`=1
- Reset wins over every other condition in the same edge, including mid-NORM and mid-WAIT. In-flight work is discarded and no `start` is emitted afterwards.
- Acceptance edge E0 (IDLE, `a_valid`=1, a≠0):
  - k = required shifts.
  - NORM occupies edges E1..E(k+1).
  - `start` is high in the cycle after edge E(k+1) (if not stalled), i.e. k+1 cycles after E0.
  - WAIT is entered at E(k+2).
- Stall: each cycle `root_busy`=1 while normalised in NORM adds one cycle before ISSUE.
- `start` width: exactly one clock period; never asserted twice per operand.
- Return to idle: `a_ready` rises the cycle after the edge sampling `root_ready`=1 in WAIT.
- Back-to-back: a new operand may be accepted at that edge.
- Zero path: `zero` is high for the single cycle after E0; `a_ready` stays 1 (next operand accepted at E1).

## Test plan
- a=0x40000000 → no shifts; `start` pulse 1 cycle after acceptance; d=0x40000000, shift=0; after `root_ready`, `a_ready`=1.
- a=0x00000001 → 15 NORM shift cycles; d=0x40000000, shift=15; `start` 16 cycles after acceptance.
- a=0x00020000 → d=0x80000000, shift=7; a=0xC0000000 → d=0xC0000000, shift=0. Chained with `root_newton`, check q·2^(16−shift) ≈ sqrt(a).
- a=0 → `zero` one-cycle pulse, `start` never asserted, `a_ready` stays 1; next operand 0xFFFE0001 accepted the following cycle, shift=0.
- Hold `root_busy`=1 for 5 cycles while normalised → `start` delayed exactly 5 cycles; d stable; `a_valid` pulses during WAIT ignored.
- Assert `clrn`=0 mid-NORM (a=1, after 4 shifts) → next cycle d=0, shift=0, `a_ready`=1, no `start`.
